// File: rtl/kbd_input_port.sv
// PS/2 keyboard receiver with byte FIFO and CPU status/data registers.
// Define PS2_PARITY_CHECK_EN to drop odd-parity-failing frames and flag perr.
module kbd_input_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        cpu_rd,
    input  logic        cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        key_avail
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e          state_q, state_d;
    logic            ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic            ps2d_s1_q, ps2d_s2_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TW-1:0]   tmo_q;
    logic            push_q, ferr_ev_q, perr_ev_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ferr_q, perr_q;

    logic            fall, din, tmo_hit, frame_end, par_ok;
    logic            accept, ferr_ev, perr_ev;
    logic            full, empty, rd_data, rd_stat, pop, push_ok, ovf_ev;
    logic [3:0]      cnt4;

    // Both raw lines idle high, so the synchronizers reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= ps2_clk;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= ps2_data;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign fall    = ps2c_prev_q & ~ps2c_s2_q;
    assign din     = ps2d_s2_q;
    assign tmo_hit = (state_q != IDLE) && !fall
                  && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:    if (!din) state_d = DATA;
                DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_end = fall && (state_q == STOP);
        par_ok    = ^{shift_q, par_q};
        accept    = frame_end & din & (par_ok | ~PAR_CHECK);
        ferr_ev   = frame_end & ~din;
        perr_ev   = frame_end & din & PAR_CHECK & ~par_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            push_q    <= 1'b0;
            ferr_ev_q <= 1'b0;
            perr_ev_q <= 1'b0;
        end else begin
            push_q    <= accept;
            ferr_ev_q <= ferr_ev;
            perr_ev_q <= perr_ev;
            if (state_q == IDLE || fall || tmo_hit) tmo_q <= '0;
            else                                    tmo_q <= tmo_q + TW'(1);
            if (state_q == IDLE || tmo_hit) begin
                bitcnt_q <= 3'd0;
            end else if (fall && state_q == DATA) begin
                shift_q[bitcnt_q] <= din;
                bitcnt_q          <= bitcnt_q + 3'd1;
            end else if (fall && state_q == PARITY) begin
                par_q <= din;
            end
        end
    end

    // shift_q is stable in the cycle after the stop edge, so it feeds the FIFO directly
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = cpu_rd & cpu_addr;
    assign rd_stat = cpu_rd & ~cpu_addr;
    assign pop     = rd_data & ~empty;
    assign push_ok = push_q & (~full | pop);
    assign ovf_ev  = push_q & full & ~pop;
    assign count_d = count_q + CW'(push_ok) - CW'(pop);
    assign cnt4    = 4'(count_q);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            cpu_rdata <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            ovf_q    <= ovf_ev    | (ovf_q  & ~rd_stat);
            ferr_q   <= ferr_ev_q | (ferr_q & ~rd_stat);
            perr_q   <= perr_ev_q | (perr_q & ~rd_stat);
            if (rd_stat)
                cpu_rdata <= {24'd0, cnt4, ferr_q, perr_q, ovf_q, key_avail};
            else if (rd_data)
                cpu_rdata <= pop ? {24'd0, mem[rd_ptr_q]} : 32'd0;
        end
    end

    assign key_avail = ~empty;

endmodule
